// File: rtl/serial_tc_pkg.sv
// Shared types and constants for the serial two's-complement framer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package serial_tc_pkg;

    // SEEK: no 1 seen yet in the current word; INVERT: a 1 has been seen.
    typedef enum logic {
        SEEK   = 1'b0,
        INVERT = 1'b1
    } state_t;

    // Legal word lengths.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // Counter width able to hold 0..w-1.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_tc_cnt.sv
// Bit-position counter: counts accepted bits 0..WIDTH-1 and wraps to 0.
// Latency: cnt updates on the edge that accepts a bit; first/last decode the current count.
// Backpressure: none; holds while inc=0, clr has priority over inc.
module serial_tc_cnt
    import serial_tc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_bits(WIDTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          first,
    output logic          last
);

    assign first = (cnt == '0);
    assign last  = (cnt == CW'(WIDTH - 1));

    // Advance on each accepted bit, wrapping after the MSB position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tc_framed.sv
// Serial LSB-first two's-complement negate / pass-through with word framing (optional ovf via SERIAL_TC_OVF_EN).
// Latency: exactly 1 cycle from accepted input bit to registered output bit.
// Backpressure: none; valid-only stream, clr aborts the current word and discards a coincident bit.
module serial_tc_framed
    import serial_tc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic in_valid,
    input  logic in_bit,
    input  logic neg,
    output logic out_valid,
    output logic out_bit,
    output logic out_last
`ifdef SERIAL_TC_OVF_EN
    ,
    output logic ovf,
    output logic ovf_sticky
`endif
);

    localparam int CW = cnt_bits(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_tc_framed: WIDTH out of range");
    end

    logic          accept;
    logic          first;
    logic          last;
    logic [CW-1:0] bit_idx;
    logic          unused_bit_idx;
    state_t        state;
    state_t        state_nxt;
    state_t        eff_state;
    logic          mode;
    logic          eff_mode;
    logic          bit_d;
    logic          ovf_d;

    assign accept         = in_valid & ~clr;
    assign unused_bit_idx = ^bit_idx;

    serial_tc_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (accept),
        .clr   (clr),
        .cnt   (bit_idx),
        .first (first),
        .last  (last)
    );

    // Next state and output bit; bit 0 always starts from SEEK with a freshly sampled mode.
    always_comb begin
        eff_state = first ? SEEK : state;
        eff_mode  = first ? neg : mode;
        bit_d     = in_bit;
        ovf_d     = 1'b0;
        state_nxt = state;
        if (eff_state == INVERT) begin
            bit_d = in_bit ^ eff_mode;
        end
        if (clr) begin
            state_nxt = SEEK;
        end else if (accept) begin
            if (last) begin
                state_nxt = SEEK;
                // Only -2^(WIDTH-1) reaches the MSB still in SEEK with a 1 there.
                ovf_d     = eff_mode & (eff_state == SEEK) & in_bit;
            end else if ((eff_state == SEEK) && in_bit) begin
                state_nxt = INVERT;
            end else begin
                state_nxt = eff_state;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode is captured on bit 0 and held for the rest of the word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode <= 1'b0;
        end else if (accept && first) begin
            mode <= neg;
        end
    end

    // Registered output stream, one bit out per accepted bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= accept;
            out_bit   <= accept & bit_d;
            out_last  <= accept & last;
        end
    end

`ifdef SERIAL_TC_OVF_EN
    // Overflow pulse with out_last, plus a sticky copy held until clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            ovf        <= accept & ovf_d;
            ovf_sticky <= clr ? 1'b0 : (ovf_sticky | (accept & ovf_d));
        end
    end
`else
    logic unused_ovf_d;
    assign unused_ovf_d = ovf_d;
`endif

endmodule

// File: tb/tb_serial_tc_framed.sv
// Scoreboard bench for serial_tc_framed at WIDTH=8 (directed words, hand-computed results).
// Driver pushes expected bits/words; a negedge monitor pops and compares.
// Covers negate, pass-through, gaps, back-to-back words, clr abort and mid-word reset.
module tb_serial_tc_framed;

    logic clk = 1'b0;
    logic rstn;
    logic clr;
    logic in_valid;
    logic in_bit;
    logic neg;
    logic out_valid;
    logic out_bit;
    logic out_last;
`ifdef SERIAL_TC_OVF_EN
    logic ovf;
    logic ovf_sticky;
`endif

    always #5 clk = ~clk;

    serial_tc_framed #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .neg        (neg),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .out_last   (out_last)
`ifdef SERIAL_TC_OVF_EN
        ,
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky)
`endif
    );

    typedef struct packed {
        logic b;
        logic last;
        logic ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] word_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       exp_vld = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; returns 1 time unit after the sampling edge.
    task automatic step(input logic v, input logic b, input logic n, input logic c);
        in_valid = v;
        in_bit   = b;
        neg      = n;
        clr      = c;
        @(posedge clk);
        exp_vld = v & ~c;
        #1;
    endtask

    // Streams nbits of w (LSB first); negv[i] is driven on neg for bit i.
    // gap_len idle cycles are inserted after bit gap_after.
    task automatic send_word(input logic [7:0] w, input logic [7:0] negv, input logic [7:0] expw,
                             input int nbits, input int gap_after, input int gap_len,
                             input logic exp_ovf);
        exp_t e;
        if (nbits == 8) word_q.push_back(expw);
        for (int i = 0; i < nbits; i++) begin
            e.b    = expw[i];
            e.last = (i == 7);
            e.ovf  = exp_ovf && (i == 7);
            exp_q.push_back(e);
            step(1'b1, w[i], negv[i], 1'b0);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'b1, 1'b1, 1'b0);
            end
        end
        in_valid = 1'b0;
    endtask

    // Reset asserted mid-word, after the in-flight output bit has been checked.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        rstn     = 1'b0;
        exp_vld  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor: compares every output cycle against the scoreboard.
    logic [7:0] acc = '0;
    int         idx = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("out_valid", 64'(out_valid), 64'(exp_vld));
            if (!rstn) begin
                check("rst_out_bit", 64'(out_bit), 64'd0);
                check("rst_out_last", 64'(out_last), 64'd0);
`ifdef SERIAL_TC_OVF_EN
                check("rst_ovf", 64'(ovf), 64'd0);
                check("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
`endif
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bit", 64'(out_bit), 64'(e.b));
                    check("out_last", 64'(out_last), 64'(e.last));
`ifdef SERIAL_TC_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.ovf));
`endif
                    if (idx < 8) acc[idx] = out_bit;
                    idx++;
                    if (out_last) begin
                        check("word_len", 64'(idx), 64'd8);
                        if (word_q.size() == 0) check("word_expected", 64'd0, 64'd1);
                        else check("word", 64'(acc), 64'(word_q.pop_front()));
                        idx = 0;
                    end
                end
            end
            if (clr || !rstn) idx = 0;
        end
    end

    initial begin
        rstn     = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        neg      = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // -6 = 0xFA, contiguous
        send_word(8'h06, 8'hFF, 8'hFA, 8, 8, 0, 1'b0);
        // zero stays zero
        send_word(8'h00, 8'hFF, 8'h00, 8, 8, 0, 1'b0);
        // most negative value maps onto itself
        send_word(8'h80, 8'hFF, 8'h80, 8, 8, 0, 1'b1);
`ifdef SERIAL_TC_OVF_EN
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_sticky_hold", 64'(ovf_sticky), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_sticky_clr", 64'(ovf_sticky), 64'd0);
`else
        step(1'b0, 1'b0, 1'b0, 1'b0);
`endif
        // -1 = 0xFF with a 3-cycle gap after bit 2
        send_word(8'h01, 8'hFF, 8'hFF, 8, 2, 3, 1'b0);
        // back-to-back, neg toggling mid-word: only bit-0 neg matters
        send_word(8'h01, 8'h55, 8'hFF, 8, 8, 0, 1'b0);
        send_word(8'h01, 8'hAA, 8'h01, 8, 8, 0, 1'b0);
        // partial word (0x16 negated -> 0xEA bits 0..4), then clr with a coincident bit
        send_word(8'h16, 8'hFF, 8'hEA, 5, 8, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        send_word(8'h03, 8'hFF, 8'hFD, 8, 8, 0, 1'b0);
        // partial word abandoned by reset, next word framed from bit 0
        send_word(8'h06, 8'hFF, 8'hFA, 3, 8, 0, 1'b0);
        mid_reset();
        send_word(8'h05, 8'hFF, 8'hFB, 8, 8, 0, 1'b0);

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("bits_drained", 64'(exp_q.size()), 64'd0);
        check("words_drained", 64'(word_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
